// File: rtl/button_conditioner_if.sv
`default_nettype none
// button_conditioner_if: raw button inputs plus the conditioned level/pulse/held outputs.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_held;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_held
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_held
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// button_conditioner: per-button 2-flop synchroniser and stability-counter debouncer with press/release pulses.
// Auto-repeat press pulses and btn_held are built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int N_BTN         = 2,
  parameter int DB_CYCLES     = 4,
  parameter int CNT_W         = 16,
  parameter int HOLD_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  button_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (DB_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("button_conditioner: DB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] held_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [1:0]       sync;
    logic [CNT_W-1:0] db_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             differ;
    logic             accept;
    logic             rise;

    // accept fires on the DB_CYCLES-th consecutive cycle that s disagrees with the level
    assign differ = sync[1] ^ level_q;
    assign accept = differ && (db_cnt == DB_LAST);
    assign rise   = accept && sync[1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync      <= 2'b00;
        db_cnt    <= '0;
        level_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync      <= {sync[0], bus.btn_in[i]};
        db_cnt    <= (differ && !accept) ? db_cnt + 1'b1 : '0;
        if (accept) begin
          level_q <= sync[1];
        end
        release_q <= accept && !sync[1];
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             held_q;
    logic             fire;

    // a falling accept blocks any repeat pulse on the release edge
    assign fire = level_q && !accept &&
                  (held_q ? (rep_cnt == REP_LAST) : (hold_cnt == HOLD_LAST));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
        held_q   <= 1'b0;
        press_q  <= 1'b0;
      end else begin
        press_q <= rise || fire;
        if (!level_q || accept) begin
          hold_cnt <= '0;
          rep_cnt  <= '0;
          held_q   <= 1'b0;
        end else if (fire) begin
          held_q  <= 1'b1;
          rep_cnt <= '0;
        end else if (held_q) begin
          rep_cnt <= rep_cnt + 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end

    assign held_w[i] = held_q;
`else
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        press_q <= 1'b0;
      end else begin
        press_q <= rise;
      end
    end

    assign held_w[i] = 1'b0;
`endif

    assign level_w[i]   = level_q;
    assign press_w[i]   = press_q;
    assign release_w[i] = release_q;
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_held    = held_w;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// tb_button_conditioner: directed stimulus, a sample-window reference model compared every cycle,
// and literal latency / repeat-schedule checks. Honours BUTTON_AUTOREPEAT_EN like the design.
module tb_button_conditioner;

  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int W    = DB + 2;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  button_conditioner_if #(.N_BTN(N)) ifc ();

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .CNT_W(16), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: raw samples taken at each rising edge; s before edge e is the
  // sample from edge e-2, so a change is accepted once samples e-2..e-DB-1 all oppose the level.
  logic [N-1:0] samp [W];
  logic [N-1:0] m_level, m_press, m_release, m_held;
  int           pc [N];

  task automatic model_clear();
    for (int k = 0; k < W; k++) samp[k] = '0;
    m_level = '0; m_press = '0; m_release = '0; m_held = '0;
    for (int c = 0; c < N; c++) pc[c] = -1;
  endtask

  task automatic model_step();
    bit all_diff;
    for (int k = W - 1; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = ifc.btn_in;
    m_press = '0;
    m_release = '0;
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int k = 2; k < W; k++) if (samp[k][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) begin
        if (!m_level[c]) begin
          m_press[c] = 1'b1;
          pc[c] = 0;
        end else begin
          m_release[c] = 1'b1;
          m_held[c] = 1'b0;
          pc[c] = -1;
        end
        m_level[c] = ~m_level[c];
      end else if (m_level[c] && AR) begin
        pc[c]++;
        if (pc[c] == HOLD || (pc[c] > HOLD && (pc[c] - HOLD) % REP == 0)) m_press[c] = 1'b1;
        if (pc[c] >= HOLD) m_held[c] = 1'b1;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("level",   int'(ifc.btn_level),   int'(m_level));
      chk("press",   int'(ifc.btn_press),   int'(m_press));
      chk("release", int'(ifc.btn_release), int'(m_release));
      chk("held",    int'(ifc.btn_held),    int'(m_held));
    end
  end

  // Counts edges (edge 1 = next rising edge) until the selected pulse shows; -1 on timeout.
  task automatic wait_sig(input int ch, input bit rel, output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #3;
      if ((rel ? ifc.btn_release[ch] : ifc.btn_press[ch]) === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    int e;
    int pulses[$];
    int exp_q[$];

    // held button through reset is a new press after release
    ifc.btn_in = 2'b11;
    settle(4);
    chk("reset_outputs_zero",
        int'({ifc.btn_level, ifc.btn_press, ifc.btn_release, ifc.btn_held}), 0);
    reset = 1'b1;
    wait_sig(0, 1'b0, e);
    chk("reset_press_latency", e, 6);
    chk("reset_press_both", int'(ifc.btn_press), 3);
    chk("reset_level_both", int'(ifc.btn_level), 3);
    ifc.btn_in = 2'b00;
    wait_sig(0, 1'b1, e);
    chk("both_release_latency", e, 6);
    chk("both_release_value", int'(ifc.btn_release), 3);
    settle(3);

    // clean press and release on channel 0
    ifc.btn_in = 2'b01;
    wait_sig(0, 1'b0, e);
    chk("clean_press_latency", e, 6);
    settle(1);
    chk("press_one_cycle", int'(ifc.btn_press[0]), 0);
    ifc.btn_in = 2'b00;
    wait_sig(0, 1'b1, e);
    chk("clean_release_latency", e, 6);
    settle(3);

    // bounce: 2-cycle pulses are rejected, final rise accepted
    ifc.btn_in = 2'b01; settle(2);
    ifc.btn_in = 2'b00; settle(2);
    ifc.btn_in = 2'b01; settle(2);
    ifc.btn_in = 2'b00; settle(2);
    chk("bounce_no_level", int'(ifc.btn_level[0]), 0);
    ifc.btn_in = 2'b01;
    wait_sig(0, 1'b0, e);
    chk("bounce_press_latency", e, 6);
    ifc.btn_in = 2'b00;
    wait_sig(0, 1'b1, e);
    chk("bounce_release_latency", e, 6);
    settle(3);

    // simultaneous press
    ifc.btn_in = 2'b11;
    wait_sig(0, 1'b0, e);
    chk("simul_press_latency", e, 6);
    chk("simul_press_value", int'(ifc.btn_press), 3);
    ifc.btn_in = 2'b00;
    wait_sig(1, 1'b1, e);
    chk("simul_release_latency", e, 6);
    settle(3);

    // reset pulse during debounce
    ifc.btn_in = 2'b01;
    settle(3);
    reset = 1'b0;
    settle(1);
    chk("midreset_zero", int'({ifc.btn_level, ifc.btn_press}), 0);
    reset = 1'b1;
    wait_sig(0, 1'b0, e);
    chk("midreset_fresh_press", e, 6);
    ifc.btn_in = 2'b00;
    wait_sig(0, 1'b1, e);
    chk("midreset_release", e, 6);
    settle(3);

    // long hold on channel 1
    ifc.btn_in = 2'b10;
    wait_sig(1, 1'b0, e);
    chk("hold_press_latency", e, 6);
    pulses.push_back(0);
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #3;
      if (ifc.btn_press[1] === 1'b1) pulses.push_back(k);
      if (k == 19) chk("held_before_p20", int'(ifc.btn_held[1]), 0);
      if (k == 20) chk("held_at_p20", int'(ifc.btn_held[1]), int'(AR));
    end
    if (AR) exp_q = '{0, 20, 28, 36, 44};
    else exp_q = '{0};
    chk("repeat_count", pulses.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pulses.size(); k++)
      chk("repeat_edge", pulses[k], exp_q[k]);
    ifc.btn_in = 2'b00;
    wait_sig(1, 1'b1, e);
    chk("hold_release_latency", e, 6);
    chk("held_clear_on_release", int'(ifc.btn_held[1]), 0);
    chk("no_press_on_release", int'(ifc.btn_press[1]), 0);
    settle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
